// File: rtl/rd_grp_scheduler_if.sv
// Request/grant bundle between the group controllers, the read scheduler and the packet encoder.
interface rd_grp_scheduler_if #(
  parameter int TOTAL_GRP = 2
);
  logic [TOTAL_GRP-1:0] i_interrupt;
  logic                 rd_req_ack;
  logic [TOTAL_GRP-1:0] int_ack;
  logic                 rd_req;
  logic [TOTAL_GRP-1:0] rd_slave_id;
  logic                 busy;
  logic                 timeout_pulse;

  modport master (
    input  i_interrupt, rd_req_ack, int_ack,
    output rd_req, rd_slave_id, busy, timeout_pulse
  );

  modport slave (
    output i_interrupt, rd_req_ack, int_ack,
    input  rd_req, rd_slave_id, busy, timeout_pulse
  );
endinterface

// File: rtl/rd_grp_scheduler.sv
// Round-robin read-service scheduler: one group granted at a time, held until int_ack.
// Define RD_SCHED_TIMEOUT_EN to compile in the watchdog that reclaims unacknowledged grants.
module rd_grp_scheduler #(
  parameter int TOTAL_GRP      = 2,
  parameter int GRP_IDX_WIDTH  = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rd_grp_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, RELEASE} state_t;

  state_t                   state;
  logic [GRP_IDX_WIDTH-1:0] ptr, gnt_idx, pick_idx, ptr_nxt;
  logic [2*TOTAL_GRP-1:0]   rot;
  logic [TOTAL_GRP-1:0]     pick_oh;
  logic                     pick_vld, gnt_live, gnt_done;
  int                       pick_off, pick_sum, gnt_inc;

  // Rotate requests so bit 0 is the current priority holder, then take the lowest set bit.
  always_comb begin
    rot      = {bus.i_interrupt, bus.i_interrupt} >> ptr;
    pick_vld = |bus.i_interrupt;
    pick_off = 0;
    for (int k = TOTAL_GRP-1; k >= 0; k--)
      if (rot[k]) pick_off = k;
    pick_sum = int'(ptr) + pick_off;
    pick_idx = GRP_IDX_WIDTH'((pick_sum >= TOTAL_GRP) ? pick_sum - TOTAL_GRP : pick_sum);
    pick_oh  = TOTAL_GRP'(1) << pick_idx;
    gnt_inc  = int'(gnt_idx) + 1;
    ptr_nxt  = (gnt_inc >= TOTAL_GRP) ? '0 : GRP_IDX_WIDTH'(gnt_inc);
    gnt_live = |(bus.i_interrupt & bus.rd_slave_id);
    gnt_done = |(bus.int_ack & bus.rd_slave_id);
  end

`ifdef RD_SCHED_TIMEOUT_EN
  logic [TO_WIDTH-1:0] wd;
  logic                wd_hit;
  assign wd_hit = (wd == TO_WIDTH'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      ptr               <= '0;
      gnt_idx           <= '0;
      bus.rd_req        <= 1'b0;
      bus.rd_slave_id   <= '0;
      bus.busy          <= 1'b0;
      bus.timeout_pulse <= 1'b0;
`ifdef RD_SCHED_TIMEOUT_EN
      wd                <= '0;
`endif
    end else begin
`ifdef RD_SCHED_TIMEOUT_EN
      bus.timeout_pulse <= 1'b0;
      if ((state == REQ || state == WAIT_DONE) && !wd_hit) wd <= wd + 1'b1;
`endif
      case (state)
        IDLE: if (pick_vld) begin
          state           <= REQ;
          gnt_idx         <= pick_idx;
          bus.rd_slave_id <= pick_oh;
          bus.rd_req      <= 1'b1;
          bus.busy        <= 1'b1;
`ifdef RD_SCHED_TIMEOUT_EN
          wd              <= '0;
`endif
        end
        // Ack beats a same-cycle interrupt drop; a withdrawn request leaves ptr alone.
        REQ: if (bus.rd_req_ack) begin
          bus.rd_req <= 1'b0;
          state      <= WAIT_DONE;
        end else if (!gnt_live) begin
          bus.rd_req      <= 1'b0;
          bus.rd_slave_id <= '0;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
`ifdef RD_SCHED_TIMEOUT_EN
        else if (wd_hit) begin
          bus.rd_req        <= 1'b0;
          bus.rd_slave_id   <= '0;
          bus.timeout_pulse <= 1'b1;
          state             <= RELEASE;
        end
`endif
        WAIT_DONE: if (gnt_done) begin
          bus.rd_slave_id <= '0;
          state           <= RELEASE;
        end
`ifdef RD_SCHED_TIMEOUT_EN
        else if (wd_hit) begin
          bus.rd_slave_id   <= '0;
          bus.timeout_pulse <= 1'b1;
          state             <= RELEASE;
        end
`endif
        // Idle gap lets the serviced group drop its interrupt before the next scan.
        RELEASE: begin
          ptr             <= ptr_nxt;
          bus.rd_slave_id <= '0;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rd_grp_scheduler.sv
// Self-checking bench for rd_grp_scheduler: vector table, corner sequences, randomized scoreboard.
module tb_rd_grp_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  rd_grp_scheduler_if #(.TOTAL_GRP(N)) bus ();

  rd_grp_scheduler #(
    .TOTAL_GRP(N), .GRP_IDX_WIDTH(2), .TIMEOUT_CYCLES(10), .TO_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] irq;
    logic         ack;
    logic [N-1:0] iack;
    logic         e_req;
    logic [N-1:0] e_id;
    logic         e_busy;
  } vec_t;

  vec_t vt [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] irq, input logic ack, input logic [N-1:0] iack);
    bus.i_interrupt = irq;
    bus.rd_req_ack  = ack;
    bus.int_ack     = iack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] irq, input int p);
    for (int k = 0; k < N; k++)
      if (((irq >> ((p + k) % N)) & N'(1)) != '0) return N'(1) << ((p + k) % N);
    return '0;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] g);
    int r = 0;
    for (int k = 0; k < N; k++) if (g == (N'(1) << k)) r = k;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [N-1:0] g_id [5];
    int           g_t  [5];
    logic [N-1:0] rr_exp [5];
    logic [N-1:0] id, prev, cur, o;
    int           ng, st, cnt, gofs, pulses, pofs;
    logic [N-1:0] nextg;
    // random scoreboard state
    int           m_ptr, m_cool, ack_dly, done_dly;
    logic [N-1:0] m_gnt, p_irq, p_iack, irq_s, exp, n_iack;
    bit           m_acked, p_ack, n_ack;

    // irq, ack, int_ack -> rd_req, rd_slave_id, busy (after the sampling edge)
    vt[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vt[1]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1};
    vt[2]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1};
    vt[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1};
    vt[4]  = '{4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0100, 1'b1};
    vt[5]  = '{4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1};
    vt[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vt[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'b1000, 1'b1};
    vt[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1000, 1'b1};
    vt[9]  = '{4'b1111, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1};
    vt[10] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vt[11] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1};
    vt[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vt[13] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1};
    vt[14] = '{4'b0011, 1'b1, 4'b0000, 1'b0, 4'b0001, 1'b1};
    vt[15] = '{4'b0011, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1};
    vt[16] = '{4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vt[17] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1};
    vt[18] = '{4'b0011, 1'b1, 4'b0000, 1'b0, 4'b0010, 1'b1};
    vt[19] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1};
    vt[20] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset state and quiet idle
    rst_n = 1'b1;
    drive('0, 1'b0, '0);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", bus.rd_req, 0);
    chk("rst_id", bus.rd_slave_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tmo", bus.timeout_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_req", bus.rd_req, 0);
      chk("idle_id", bus.rd_slave_id, 0);
      chk("idle_busy", bus.busy, 0);
    end

    // vector table
    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(vt[i].irq, vt[i].ack, vt[i].iack);
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), bus.rd_req, vt[i].e_req);
      chk($sformatf("vec%0d_id", i), bus.rd_slave_id, vt[i].e_id);
      chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].e_busy);
    end

    // all groups requesting: strict rotation with >=4 cycle spacing
    do_reset();
    drive(4'b1111, 1'b0, '0);
    ng = 0; st = 0; cnt = 0; prev = '0; cur = '0;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      @(negedge clk);
      id = bus.rd_slave_id;
      if (id != '0 && prev == '0) begin
        g_id[ng] = id;
        g_t[ng]  = c;
        ng++;
      end
      prev = id;
      bus.rd_req_ack = 1'b0;
      bus.int_ack    = '0;
      case (st)
        0: if (bus.rd_req) begin cur = id; cnt = 1; st = 1; end
        1: if (cnt == 0) begin bus.rd_req_ack = 1'b1; cnt = 2; st = 2; end else cnt--;
        default: if (cnt == 0) begin bus.int_ack = cur; st = 0; end else cnt--;
      endcase
    end
    chk("rr_count", ng, 5);
    for (int i = 0; i < ng; i++) chk($sformatf("rr_order%0d", i), g_id[i], rr_exp[i]);
    for (int i = 1; i < ng; i++) chk($sformatf("rr_gap%0d", i), (g_t[i] - g_t[i-1]) >= 4, 1);

    // unacknowledged grant: watchdog reclaims it (or waits forever without the watchdog)
    do_reset();
    drive(4'b0011, 1'b0, '0);
    gofs = -1;
    for (int c = 0; c < 5 && gofs < 0; c++) begin
      @(negedge clk);
      if (bus.rd_slave_id != '0) gofs = c;
    end
    chk("to_grant", bus.rd_slave_id, 4'b0001);
    pulses = 0; pofs = -1; nextg = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.timeout_pulse) begin
        pulses++;
        if (pofs < 0) pofs = c;
      end else if (pofs >= 0 && nextg == '0 && bus.rd_slave_id != '0) begin
        nextg = bus.rd_slave_id;
      end
    end
`ifdef RD_SCHED_TIMEOUT_EN
    chk("to_pulses", pulses, 1);
    chk("to_offset", pofs, 11);
    chk("to_next_grant", nextg, 4'b0010);
`else
    chk("to_pulses", pulses, 0);
    chk("to_hold_id", bus.rd_slave_id, 4'b0001);
    chk("to_hold_req", bus.rd_req, 1);
`endif

    // asynchronous reset during WAIT_DONE, stale int_ack afterwards
    do_reset();
    drive(4'b0001, 1'b0, '0);
    @(negedge clk);
    drive(4'b0001, 1'b1, '0);
    @(negedge clk);
    drive(4'b0000, 1'b0, '0);
    chk("ar_wait_id", bus.rd_slave_id, 4'b0001);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_id", bus.rd_slave_id, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_req", bus.rd_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 1'b0, 4'b0001);
    @(negedge clk);
    drive('0, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      chk("ar_post_id", bus.rd_slave_id, 0);
      chk("ar_post_busy", bus.busy, 0);
      @(negedge clk);
    end

    // randomized traffic against a grant-level scoreboard
    do_reset();
    m_ptr = 0; m_cool = 0; ack_dly = 0; done_dly = 0;
    m_gnt = '0; p_irq = '0; p_iack = '0; irq_s = '0; m_acked = 0; p_ack = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      chk("rnd_tmo", bus.timeout_pulse, 0);
      if (m_gnt == '0) begin
        exp = (m_cool == 0) ? rr_pick(p_irq, m_ptr) : '0;
        if (m_cool > 0) m_cool--;
        chk("rnd_gnt_id", bus.rd_slave_id, exp);
        chk("rnd_gnt_req", bus.rd_req, exp != '0);
        chk("rnd_gnt_busy", bus.busy, exp != '0);
        if (exp != '0) begin
          m_gnt = exp; m_acked = 0; ack_dly = $urandom_range(0, 3);
        end
      end else if (!m_acked) begin
        if (p_ack) begin
          chk("rnd_ack_id", bus.rd_slave_id, m_gnt);
          chk("rnd_ack_req", bus.rd_req, 0);
          m_acked = 1; done_dly = $urandom_range(0, 4);
        end else if ((p_irq & m_gnt) == '0) begin
          chk("rnd_drop_id", bus.rd_slave_id, 0);
          chk("rnd_drop_req", bus.rd_req, 0);
          chk("rnd_drop_busy", bus.busy, 0);
          m_gnt = '0;
        end else begin
          chk("rnd_req_id", bus.rd_slave_id, m_gnt);
          chk("rnd_req_req", bus.rd_req, 1);
        end
      end else begin
        if ((p_iack & m_gnt) != '0) begin
          chk("rnd_done_id", bus.rd_slave_id, 0);
          chk("rnd_done_busy", bus.busy, 1);
          m_ptr = (oh2idx(m_gnt) + 1) % N;
          irq_s &= ~m_gnt;
          m_gnt = '0; m_cool = 1;
        end else begin
          chk("rnd_wait_id", bus.rd_slave_id, m_gnt);
          chk("rnd_wait_req", bus.rd_req, 0);
          chk("rnd_wait_busy", bus.busy, 1);
        end
      end
      n_ack = 0; n_iack = '0;
      irq_s |= N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      if (m_gnt != '0 && !m_acked) begin
        if (ack_dly == 0) n_ack = 1; else ack_dly--;
        if (!n_ack && $urandom_range(0, 11) == 0) irq_s &= ~m_gnt;
      end else if (m_gnt != '0) begin
        if (done_dly == 0) n_iack = m_gnt;
        else begin
          done_dly--;
          o = N'(1) << $urandom_range(0, N-1);
          if ($urandom_range(0, 4) == 0 && o != m_gnt) n_iack = o;
        end
      end else if ($urandom_range(0, 6) == 0) begin
        n_iack = N'(1) << $urandom_range(0, N-1);
      end
      drive(irq_s, n_ack, n_iack);
      p_irq = irq_s; p_ack = n_ack; p_iack = n_iack;
    end
    drive('0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
